clock_mode_ctrl: RTL
====================

# clock_mode_ctrl

Moore-style mode controller for the digital clock. It turns three front-panel buttons and two event inputs into mutually exclusive control strobes for the time-set, countdown-timer and alarm datapaths. It sequences digit entry by stepping the 3-bit digit `select` used by those datapaths. It also owns the expiry/alarm ring state with an auto-silence timeout. It sits between the panel inputs and the `Timer`/clock/alarm blocks and is the only driver of their `load`, `tmrin`, `almin`, `tmr`, `tmrp` and `alm` inputs.

## Interface
- `RING_CYCLES`, default 30: number of `clk_out` cycles the buzzer sounds before auto-silence (minimum 2).
- `clk_out` in 1: system tick; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mode_btn` in 1: level button; a rising edge advances the mode.
- `start_btn` in 1: level button; a rising edge starts/pauses the timer or silences the buzzer.
- `next_btn` in 1: level button; a rising edge advances the digit select in set modes.
- `buzz2` in 1: timer-expired flag from `Timer`.
- `alarm_match` in 1: one-or-more-cycle pulse from the alarm comparator.
- `select` out 3: digit index 0..5 (0 = seconds units … 5 = hours tens).
- `load` out 1: clock-time set enable.
- `tmrin` out 1: timer preset entry enable.
- `almin` out 1: alarm-time set enable.
- `tmr` out 1: timer run/display enable.
- `tmrp` out 1: timer pause.
- `alm` out 1: alarm-mode active; inhibits timer counting.
- `buzz_out` out 1: buzzer drive.
- `state_o` out 3: current state encoding, for display mux and debug.

## Operation
- Button edge detect: `press_x = x & ~x_q`, with `x_q` registered each cycle. `x_q` resets to 1, so a button held through reset release is not a press.
- Same-cycle press priority: mode > start > next. The lower-priority presses in that cycle are discarded.
- States and encoding: CLOCK=0, SET_CLK=1, SET_TMR=2, SET_ALM=3, TMR_RUN=4, TMR_PAUSE=5, RING_TMR=6, RING_ALM=7.
- Transitions:
  - CLOCK: mode→SET_CLK. `alarm_match` or `alm_pend`→RING_ALM.
  - SET_CLK: mode→SET_TMR.
  - SET_TMR: mode→SET_ALM; start→TMR_RUN.
  - SET_ALM: mode→CLOCK.
  - TMR_RUN: start→TMR_PAUSE; mode→CLOCK (timer abandoned); `buzz2`→RING_TMR.
  - TMR_PAUSE: start→TMR_RUN; mode→CLOCK. `buzz2` is ignored.
  - RING_TMR / RING_ALM: any press, or ring counter reaching `RING_CYCLES-1`→CLOCK.
  - In TMR_RUN, `buzz2` outranks a same-cycle start press but not a mode press.
- Output decode (registered from next state):
  - `load`=1 in SET_CLK only.
  - `tmrin`=1 in SET_TMR only.
  - `almin`=1 in SET_ALM only.
  - `tmr`=1 in TMR_RUN, TMR_PAUSE and RING_TMR.
  - `tmrp`=1 in TMR_PAUSE.
  - `alm`=1 in SET_ALM and RING_ALM.
  - `buzz_out`=1 in both RING states.
  - At most one of `load`/`tmrin`/`almin` is ever high.
- `select`:
  - Cleared to 0 on entry to any SET state.
  - A next press in a SET state increments it mod 6 (5→0).
  - Held at 0 outside SET states.
- `alm_pend`:
  - Set when `alarm_match` is high in any state other than CLOCK or RING_ALM.
  - Cleared on entry to RING_ALM.
  - While set, it forces CLOCK→RING_ALM on the first CLOCK cycle.
  - Holding `alarm_match` high across a RING_ALM exit does not retrigger the ring. A new rising level of `alarm_match` is required, so `alarm_match` is edge-qualified internally.
- Ring counter:
  - Width `$clog2(RING_CYCLES)`.
  - Cleared on entry to a RING state; increments each cycle while in a RING state.
  - Cleared whenever the controller is outside a RING state.

## Timing
- Reset (asynchronous, immediate):
  - State CLOCK.
  - `select`=0; all strobes, `buzz_out`, `alm_pend`, `state_o` and the ring counter = 0.
  - Button `_q` registers = 1.
- Latency: a button first sampled high at edge k changes state and all outputs at edge k. The outputs are valid in cycle k+1. No combinational path exists from inputs to outputs.
- `buzz2` sampled high at edge k in TMR_RUN: `buzz_out`=1 from edge k.
- Ring duration: `buzz_out` is high for exactly `RING_CYCLES` cycles if no press occurs.
- Reset asserted mid-ring or mid-set: returns to CLOCK asynchronously; `alm_pend` is lost.

## Test plan
- **Reset and mode cycle:** Reset, then 4 mode presses. Required: `state_o` 0→1→2→3→0. `load`, `tmrin`, `almin` each high in exactly one step. All outputs 0 during reset.
- **Digit select wrap:** In SET_TMR, 7 next presses. Required: `select` 1,2,3,4,5,0,1. A mode+next press in the same cycle gives SET_ALM with `select`=0.
- **Timer start, pause, expiry:** From SET_TMR, start → `tmr`=1, `tmrp`=0. Start again → `tmrp`=1. Then `buzz2`=1 → state stays 5. Start → state 4. `buzz2`=1 → state 6 with `buzz_out`=1 at the same edge.
- **Ring auto-silence:** `RING_CYCLES`=30 in RING_TMR with no press. Required: `buzz_out` high exactly 30 cycles, then CLOCK. A repeat run with start pressed at ring cycle 5 gives CLOCK at that edge.
- **Pending alarm:** Pulse `alarm_match` while in TMR_RUN. Required: no state change. After a mode press to CLOCK → RING_ALM next edge, `alm`=1, `alm_pend` cleared.
- **Held-button reset release:** Hold `mode_btn` high through reset release. Required: state stays CLOCK until the button is released and pressed again.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_mode_ctrl
// Brief    : Panel-button mode controller for the digital clock. Produces the
//            set/timer/alarm strobes, the digit select and the ring state.
// Revision : 1.0 - initial release
// ============================================================================
module clock_mode_ctrl #(
    parameter int RING_CYCLES = 30
) (
    input  logic       clk_out,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       start_btn,
    input  logic       next_btn,
    input  logic       buzz2,
    input  logic       alarm_match,
    output logic [2:0] select,
    output logic       load,
    output logic       tmrin,
    output logic       almin,
    output logic       tmr,
    output logic       tmrp,
    output logic       alm,
    output logic       buzz_out,
    output logic [2:0] state_o
);

    localparam int                 c_CNT_W     = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_RING_LAST = c_CNT_W'(RING_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [2:0] {
        ST_CLOCK     = 3'd0,
        ST_SET_CLK   = 3'd1,
        ST_SET_TMR   = 3'd2,
        ST_SET_ALM   = 3'd3,
        ST_TMR_RUN   = 3'd4,
        ST_TMR_PAUSE = 3'd5,
        ST_RING_TMR  = 3'd6,
        ST_RING_ALM  = 3'd7
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_mode_q;
    logic                 r_start_q;
    logic                 r_next_q;
    logic                 r_am_q;
    logic                 r_alm_pend;
    logic [c_CNT_W-1:0]   r_ring_cnt;
    logic [2:0]           r_select;
    logic                 r_load;
    logic                 r_tmrin;
    logic                 r_almin;
    logic                 r_tmr;
    logic                 r_tmrp;
    logic                 r_alm;
    logic                 r_buzz;

    logic                 w_press_mode;
    logic                 w_press_start;
    logic                 w_press_next;
    logic                 w_any_press;
    logic                 w_am_rise;
    logic                 w_ring_done;
    logic                 w_next_set;
    logic                 w_next_ring;
    logic [2:0]           w_select;
    logic                 w_alm_pend;
    logic [c_CNT_W-1:0]   w_ring_cnt;
    logic                 w_load;
    logic                 w_tmrin;
    logic                 w_almin;
    logic                 w_tmr;
    logic                 w_tmrp;
    logic                 w_alm;
    logic                 w_buzz;

    // One press per cycle: mode beats start beats next.
    assign w_press_mode  = mode_btn & ~r_mode_q;
    assign w_press_start = start_btn & ~r_start_q & ~w_press_mode;
    assign w_press_next  = next_btn & ~r_next_q & ~w_press_mode & ~w_press_start;
    assign w_any_press   = w_press_mode | w_press_start | w_press_next;
    assign w_am_rise     = alarm_match & ~r_am_q;
    assign w_ring_done   = (r_ring_cnt == c_RING_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CLOCK: begin
                // A due alarm wins over a mode press so it is never lost.
                if (w_am_rise || r_alm_pend) w_next = ST_RING_ALM;
                else if (w_press_mode)       w_next = ST_SET_CLK;
            end
            ST_SET_CLK: begin
                if (w_press_mode) w_next = ST_SET_TMR;
            end
            ST_SET_TMR: begin
                if (w_press_mode)       w_next = ST_SET_ALM;
                else if (w_press_start) w_next = ST_TMR_RUN;
            end
            ST_SET_ALM: begin
                if (w_press_mode) w_next = ST_CLOCK;
            end
            ST_TMR_RUN: begin
                if (w_press_mode)       w_next = ST_CLOCK;
                else if (buzz2)         w_next = ST_RING_TMR;
                else if (w_press_start) w_next = ST_TMR_PAUSE;
            end
            ST_TMR_PAUSE: begin
                if (w_press_mode)       w_next = ST_CLOCK;
                else if (w_press_start) w_next = ST_TMR_RUN;
            end
            ST_RING_TMR, ST_RING_ALM: begin
                if (w_any_press || w_ring_done) w_next = ST_CLOCK;
            end
            default: w_next = ST_CLOCK;
        endcase
    end

    always_comb begin
        w_next_set  = (w_next == ST_SET_CLK) || (w_next == ST_SET_TMR) || (w_next == ST_SET_ALM);
        w_next_ring = (w_next == ST_RING_TMR) || (w_next == ST_RING_ALM);

        w_load  = (w_next == ST_SET_CLK);
        w_tmrin = (w_next == ST_SET_TMR);
        w_almin = (w_next == ST_SET_ALM);
        w_tmr   = (w_next == ST_TMR_RUN) || (w_next == ST_TMR_PAUSE) || (w_next == ST_RING_TMR);
        w_tmrp  = (w_next == ST_TMR_PAUSE);
        w_alm   = (w_next == ST_SET_ALM) || (w_next == ST_RING_ALM);
        w_buzz  = w_next_ring;

        w_select = 3'd0;
        if (w_next_set && (w_next == r_state) && w_press_next) begin
            w_select = (r_select == 3'd5) ? 3'd0 : r_select + 3'd1;
        end else if (w_next_set && (w_next == r_state)) begin
            w_select = r_select;
        end

        w_alm_pend = r_alm_pend;
        if ((w_next == ST_RING_ALM) && (r_state != ST_RING_ALM)) begin
            w_alm_pend = 1'b0;
        end else if (w_am_rise && (r_state != ST_CLOCK) && (r_state != ST_RING_ALM)) begin
            w_alm_pend = 1'b1;
        end

        w_ring_cnt = '0;
        if (w_next_ring && (w_next == r_state)) begin
            w_ring_cnt = r_ring_cnt + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            r_state    <= ST_CLOCK;
            r_mode_q   <= 1'b1;
            r_start_q  <= 1'b1;
            r_next_q   <= 1'b1;
            r_am_q     <= 1'b0;
            r_alm_pend <= 1'b0;
            r_ring_cnt <= '0;
            r_select   <= 3'd0;
            r_load     <= 1'b0;
            r_tmrin    <= 1'b0;
            r_almin    <= 1'b0;
            r_tmr      <= 1'b0;
            r_tmrp     <= 1'b0;
            r_alm      <= 1'b0;
            r_buzz     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_mode_q   <= mode_btn;
            r_start_q  <= start_btn;
            r_next_q   <= next_btn;
            r_am_q     <= alarm_match;
            r_alm_pend <= w_alm_pend;
            r_ring_cnt <= w_ring_cnt;
            r_select   <= w_select;
            r_load     <= w_load;
            r_tmrin    <= w_tmrin;
            r_almin    <= w_almin;
            r_tmr      <= w_tmr;
            r_tmrp     <= w_tmrp;
            r_alm      <= w_alm;
            r_buzz     <= w_buzz;
        end
    end

    assign select   = r_select;
    assign load     = r_load;
    assign tmrin    = r_tmrin;
    assign almin    = r_almin;
    assign tmr      = r_tmr;
    assign tmrp     = r_tmrp;
    assign alm      = r_alm;
    assign buzz_out = r_buzz;
    assign state_o  = r_state;

endmodule
`default_nettype wire
